// File: rtl/cmd_arbiter.sv
// cmd_arbiter: round-robin arbiter for 4 requesters feeding one command channel,
// sequencing START -> RD/WR -> ACK -> DONE. Optional ACK timeout: CMD_ARB_TIMEOUT_EN.
`default_nettype none

module cmd_arbiter #(
   parameter int               CNT_W       = 16,
   parameter logic [CNT_W-1:0] C_START_LEN = 16'h0008,
   parameter logic [CNT_W-1:0] C_XFER_LEN  = 16'h0010,
   parameter logic [CNT_W-1:0] C_ACK_TO    = 16'h00FF,
   parameter logic [7:0]       C_CMD_IDLE  = 8'h00,
   parameter logic [7:0]       C_CMD_START = 8'h80,
   parameter logic [7:0]       C_CMD_WR    = 8'h40,
   parameter logic [7:0]       C_CMD_RD    = 8'h20,
   parameter logic [7:0]       C_CMD_ACK   = 8'hFF
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       ena,
   input  logic [3:0] req,
   input  logic [3:0] req_wr,
   input  logic       ack_in,
   output logic [3:0] gnt,
   output logic [1:0] owner,
   output logic [7:0] cmd_type,
   output logic       busy,
   output logic [3:0] done,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_XFER  = 3'd2,
      S_ACK   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Zero-length phases still occupy one cycle.
   localparam logic [CNT_W-1:0] START_LAST = (C_START_LEN == '0) ? '0 : C_START_LEN - 1'b1;
   localparam logic [CNT_W-1:0] XFER_LAST  = (C_XFER_LEN  == '0) ? '0 : C_XFER_LEN  - 1'b1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       last;
   logic             wr;

   logic             win_found;
   logic [1:0]       win_idx;

   // Scan starts just after the previous owner; i==4 wraps back onto it.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last;
      for (int i = 1; i <= 4; i++) begin
         logic [1:0] cand;
         cand = last + i[1:0];
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

`ifdef CMD_ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] ACK_LAST = (C_ACK_TO == '0) ? '0 : C_ACK_TO - 1'b1;
`else
   logic unused_ack_to;
   assign unused_ack_to = ^C_ACK_TO;
   assign err           = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (Reset) begin
         state    <= S_IDLE;
         gnt      <= 4'b0000;
         owner    <= 2'd0;
         cmd_type <= C_CMD_IDLE;
         busy     <= 1'b0;
         done     <= 4'b0000;
         cnt      <= '0;
         last     <= 2'd3;
         wr       <= 1'b0;
`ifdef CMD_ARB_TIMEOUT_EN
         err      <= 1'b0;
`endif
      end else begin
         done <= 4'b0000;
`ifdef CMD_ARB_TIMEOUT_EN
         err  <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (ena && win_found) begin
                  gnt      <= 4'b0001 << win_idx;
                  owner    <= win_idx;
                  wr       <= req_wr[win_idx];
                  cmd_type <= C_CMD_START;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= S_START;
               end
            end
            S_START: begin
               if (cnt == START_LAST) begin
                  cnt      <= '0;
                  cmd_type <= wr ? C_CMD_WR : C_CMD_RD;
                  state    <= S_XFER;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_XFER: begin
               if (cnt == XFER_LAST) begin
                  cnt      <= '0;
                  cmd_type <= C_CMD_ACK;
                  state    <= S_ACK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_ACK: begin
               if (ack_in) begin
                  cnt      <= '0;
                  cmd_type <= C_CMD_IDLE;
                  state    <= S_DONE;
`ifdef CMD_ARB_TIMEOUT_EN
               end else if (cnt == ACK_LAST) begin
                  cnt      <= '0;
                  err      <= 1'b1;
                  cmd_type <= C_CMD_IDLE;
                  state    <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
`endif
               end
            end
            S_DONE: begin
               done  <= 4'b0001 << owner;
               gnt   <= 4'b0000;
               busy  <= 1'b0;
               last  <= owner;
               state <= S_IDLE;
            end
            default: begin
               state    <= S_IDLE;
               gnt      <= 4'b0000;
               cmd_type <= C_CMD_IDLE;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter: timeline reference model feeds a per-cycle expectation queue;
// a negedge monitor pops and compares every DUT output.
`default_nettype none

module tb_cmd_arbiter;

   localparam int S_LEN  = 8;
   localparam int X_LEN  = 16;
   localparam int ACK_TO = 4;

   logic       clk = 1'b0;
   logic       Reset;
   logic       ena;
   logic [3:0] req;
   logic [3:0] req_wr;
   logic       ack_in;
   logic [3:0] gnt;
   logic [1:0] owner;
   logic [7:0] cmd_type;
   logic       busy;
   logic [3:0] done;
   logic       err;

   cmd_arbiter #(
      .CNT_W      (16),
      .C_START_LEN(16'h0008),
      .C_XFER_LEN (16'h0010),
      .C_ACK_TO   (16'h0004)
   ) dut (
      .clk     (clk),
      .Reset   (Reset),
      .ena     (ena),
      .req     (req),
      .req_wr  (req_wr),
      .ack_in  (ack_in),
      .gnt     (gnt),
      .owner   (owner),
      .cmd_type(cmd_type),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] owner;
      logic [7:0] cmd;
      logic       busy;
      logic [3:0] done;
      logic       err;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] grant_log[$];

   // Reference model: a transaction is a timeline measured from its grant edge.
   bit         m_active   = 1'b0;
   bit         m_ack_done = 1'b0;
   int         m_t        = 0;
   int         m_end_t    = 0;
   logic [1:0] m_owner    = 2'd0;
   logic [1:0] m_last     = 2'd3;
   bit         m_wr       = 1'b0;

   always @(posedge clk) begin
      exp_t       e;
      logic [3:0] m_done;
      bit         m_err;
      m_done = 4'b0000;
      m_err  = 1'b0;
      if (Reset) begin
         m_active = 1'b0;
         m_owner  = 2'd0;
         m_last   = 2'd3;
      end else if (m_active) begin
         if (m_ack_done && m_t == m_end_t) begin
            m_active        = 1'b0;
            m_done[m_owner] = 1'b1;
            m_last          = m_owner;
         end else begin
            if (!m_ack_done && m_t >= S_LEN + X_LEN) begin
               if (ack_in) begin
                  m_ack_done = 1'b1;
                  m_end_t    = m_t + 1;
               end
`ifdef CMD_ARB_TIMEOUT_EN
               else if (m_t - (S_LEN + X_LEN) == ACK_TO - 1) begin
                  m_ack_done = 1'b1;
                  m_end_t    = m_t + 1;
                  m_err      = 1'b1;
               end
`endif
            end
            m_t++;
         end
      end else if (ena && req != 4'b0000) begin
         for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (int'(m_last) + k) % 4;
            if (!m_active && req[idx]) begin
               m_active   = 1'b1;
               m_owner    = 2'(idx);
               m_wr       = req_wr[idx];
               m_t        = 0;
               m_ack_done = 1'b0;
            end
         end
      end
      e.gnt   = m_active ? (4'b0001 << m_owner) : 4'b0000;
      e.owner = m_owner;
      e.busy  = m_active;
      e.done  = m_done;
      e.err   = m_err;
      if (!m_active || m_ack_done)  e.cmd = 8'h00;
      else if (m_t < S_LEN)         e.cmd = 8'h80;
      else if (m_t < S_LEN + X_LEN) e.cmd = m_wr ? 8'h40 : 8'h20;
      else                          e.cmd = 8'hFF;
      exp_q.push_back(e);
   end

   logic [3:0] prev_gnt = 4'b0000;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         exp_t a;
         e = exp_q.pop_front();
         a = '{gnt: gnt, owner: owner, cmd: cmd_type, busy: busy, done: done, err: err};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL cycle_outputs t=%0t actual gnt=%b owner=%0d cmd=%h busy=%b done=%b err=%b required gnt=%b owner=%0d cmd=%h busy=%b done=%b err=%b",
                     $time, a.gnt, a.owner, a.cmd, a.busy, a.done, a.err,
                     e.gnt, e.owner, e.cmd, e.busy, e.done, e.err);
         end
      end
      if (prev_gnt == 4'b0000 && gnt != 4'b0000) grant_log.push_back(owner);
      prev_gnt = gnt;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick(2);
      Reset = 1'b0;
   endtask

   initial begin
      Reset  = 1'b1;
      ena    = 1'b0;
      req    = 4'b0000;
      req_wr = 4'b0000;
      ack_in = 1'b0;
      tick(3);
      Reset = 1'b0;
      tick(2);

      // Rotation from reset under full request load.
      ena    = 1'b1;
      ack_in = 1'b1;
      req    = 4'b1111;
      req_wr = 4'b1010;
      grant_log.delete();
      tick(120);
      req = 4'b0000;
      tick(30);
      checks++;
      if (grant_log.size() < 5) begin
         failures++;
         $display("FAIL rr_grant_count actual=%0d required>=5", grant_log.size());
      end else begin
         logic [1:0] order[5];
         order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (grant_log[i] !== order[i]) begin
               failures++;
               $display("FAIL rr_order[%0d] actual=%0d required=%0d", i, grant_log[i], order[i]);
            end
         end
      end

      // Single write on requester 2.
      req    = 4'b0100;
      req_wr = 4'b0100;
      tick(20);
      req = 4'b0000;
      tick(15);

      // Read with request dropped during the transfer phase.
      req    = 4'b0001;
      req_wr = 4'b0000;
      tick(14);
      req = 4'b0000;
      tick(25);

      // Reset in the middle of a transfer, then priority restarts at req[0].
      req    = 4'b0010;
      req_wr = 4'b0010;
      tick(14);
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      req   = 4'b1111;
      tick(3);
      req = 4'b0000;
      tick(30);

      // ena gating.
      ena = 1'b0;
      req = 4'b0001;
      tick(6);
      ena = 1'b1;
      tick(3);
      req = 4'b0000;
      tick(30);

      // Delayed acknowledge.
      ack_in = 1'b0;
      req    = 4'b1000;
      tick(35);
      ack_in = 1'b1;
      req    = 4'b0000;
      tick(5);

`ifdef CMD_ARB_TIMEOUT_EN
      do_reset();
      ack_in = 1'b0;
      req    = 4'b0001;
      tick(1);
      req = 4'b0000;
      tick(40);
      req = 4'b0001;
      tick(1);
      req = 4'b0000;
      tick(27);
      ack_in = 1'b1;
      tick(5);
`endif

      // Randomized traffic.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         Reset  = ($urandom_range(0, 599) == 0);
         ena    = ($urandom_range(0, 9) != 0);
         req    = 4'($urandom_range(0, 15));
         req_wr = 4'($urandom_range(0, 15));
         ack_in = ($urandom_range(0, 2) == 0);
         tick(1);
      end
      Reset  = 1'b0;
      req    = 4'b0000;
      ack_in = 1'b1;
      tick(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
